// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the program counter, fetches from instruction memory
// and hands the latched instruction to execute; supports stall, halt and fetch timeout.
`default_nettype none

module pc_fetch_sequencer #(
  parameter int PC_W     = 5,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_instr_rdata,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr_out,
  input  logic            i_exec_done,
  input  logic            i_br_taken,
  input  logic [PC_W-1:0] i_br_target,
  input  logic            i_stall,
  input  logic            i_halt_req,
  output logic [PC_W-1:0] o_pc,
  output logic            o_halted,
  output logic            o_fetch_err
);

  localparam logic [PC_W-1:0] c_RESET_PC = RESET_PC[PC_W-1:0];
  localparam logic [7:0]      c_TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [PC_W-1:0] c_PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_nxt;
  logic [31:0]     r_instr;
  logic [31:0]     w_instr_nxt;
  logic            r_imem_req;
  logic            r_instr_valid;
  logic            r_halted;
  logic            r_fetch_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc          <= c_RESET_PC;
      r_cnt         <= 8'd0;
      r_instr       <= 32'd0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_cnt         <= w_cnt_nxt;
      r_instr       <= w_instr_nxt;
      // Status outputs are registered copies of the state being entered
      r_imem_req    <= (w_state_nxt == S_FETCH);
      r_instr_valid <= (w_state_nxt == S_EXEC);
      r_halted      <= (w_state_nxt == S_HALT);
      r_fetch_err   <= (w_state_nxt == S_ERROR);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_instr_nxt = r_instr;
    case (r_state)
      S_IDLE: begin
        if (i_halt_req)
          w_state_nxt = S_HALT;
        else if (!i_stall)
          w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack) begin
          w_instr_nxt = i_instr_rdata;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_EXEC;
        end else if (r_cnt == c_TMO_LAST) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_EXEC: begin
        // A stalled exec_done is not accepted, so branch inputs are ignored too
        if (i_exec_done && !i_stall) begin
          w_pc_nxt    = i_br_taken ? i_br_target : (r_pc + c_PC_ONE);
          w_state_nxt = i_halt_req ? S_HALT : S_FETCH;
        end
      end
      default: ;
    endcase
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_instr_out   = r_instr;
  assign o_pc          = r_pc;
  assign o_halted      = r_halted;
  assign o_fetch_err   = r_fetch_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: scenario tasks with a queue of
// expected instruction words pushed at fetch and popped when execute sees them.
`default_nettype none

module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack;
  logic [31:0] instr_rdata;
  logic        exec_done;
  logic        br_taken;
  logic [4:0]  br_target;
  logic        stall;
  logic        halt_req;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [4:0]  pc;
  logic        halted;
  logic        fetch_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.PC_W(5), .RESET_PC(0), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_instr_rdata(instr_rdata),
    .o_instr_valid(instr_valid),
    .o_instr_out  (instr_out),
    .i_exec_done  (exec_done),
    .i_br_taken   (br_taken),
    .i_br_target  (br_target),
    .i_stall      (stall),
    .i_halt_req   (halt_req),
    .o_pc         (pc),
    .o_halted     (halted),
    .o_fetch_err  (fetch_err)
  );

  function automatic logic [31:0] mem_word(input logic [4:0] a);
    return 32'hC0DE_0000 | {16'h0, 3'b000, a, 3'b000, a};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic quiet();
    imem_ack    = 1'b0;
    instr_rdata = 32'd0;
    exec_done   = 1'b0;
    br_taken    = 1'b0;
    br_target   = 5'd0;
    stall       = 1'b0;
    halt_req    = 1'b0;
  endtask

  task automatic sb_check(input string name);
    logic [31:0] exp_w;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: instr_valid with empty scoreboard, instr_out=%h", name, instr_out);
    end else begin
      exp_w = sb.pop_front();
      if (instr_out !== exp_w) begin
        n_fail++;
        $display("FAIL %s: instr_out=%h expected %h", name, instr_out, exp_w);
      end
    end
  endtask

  // Leaves the DUT in its first FETCH cycle at pc=0
  task automatic test_reset();
    quiet();
    rst = 1'b0;
    sb.delete();
    tick();
    tick();
    n_checks++;
    if (pc !== 5'd0 || imem_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_pc: pc=%0d addr=%0d expected 0/0", pc, imem_addr);
    end
    n_checks++;
    if ({imem_req, instr_valid, halted, fetch_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: req/valid/halted/err=%b expected 0000",
               {imem_req, instr_valid, halted, fetch_err});
    end
    n_checks++;
    if (instr_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_instr: instr_out=%h expected 0", instr_out);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL first_fetch: req=%b addr=%0d expected 1/0", imem_req, imem_addr);
    end
  endtask

  // From a FETCH cycle at start_pc, run n_instr instructions with ack/exec_done held high
  task automatic test_sequential(input logic [4:0] start_pc, input int n_instr);
    logic [4:0] exp_pc;
    exp_pc    = start_pc;
    imem_ack  = 1'b1;
    exec_done = 1'b1;
    for (int i = 0; i < n_instr; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== exp_pc || pc !== exp_pc) begin
        n_fail++;
        $display("FAIL seq_fetch: req=%b valid=%b addr=%0d pc=%0d expected 1/0/%0d/%0d",
                 imem_req, instr_valid, imem_addr, pc, exp_pc, exp_pc);
      end
      instr_rdata = mem_word(imem_addr);
      sb.push_back(mem_word(exp_pc));
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== exp_pc) begin
        n_fail++;
        $display("FAIL seq_exec: valid=%b req=%b pc=%0d expected 1/0/%0d",
                 instr_valid, imem_req, pc, exp_pc);
      end
      sb_check("seq_instr");
      instr_rdata = 32'hDEAD_BEEF;
      tick();
      exp_pc = exp_pc + 5'd1;
    end
    quiet();
  endtask

  // Starts at FETCH pc=0 (just wrapped from 31); ends in EXEC at pc=7
  task automatic test_branch();
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    br_taken  = 1'b1;
    br_target = 5'd7;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 5'd0 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL br_ignored_in_fetch: req=%b addr=%0d valid=%b expected 1/0/0",
               imem_req, imem_addr, instr_valid);
    end
    exec_done   = 1'b0;
    br_taken    = 1'b0;
    imem_ack    = 1'b1;
    instr_rdata = mem_word(5'd0);
    sb.push_back(mem_word(5'd0));
    tick();
    sb_check("br_instr0");
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    br_taken  = 1'b1;
    br_target = 5'd7;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 5'd7 || pc !== 5'd7) begin
      n_fail++;
      $display("FAIL br_redirect: req=%b addr=%0d pc=%0d expected 1/7/7", imem_req, imem_addr, pc);
    end
    exec_done   = 1'b0;
    br_taken    = 1'b0;
    imem_ack    = 1'b1;
    instr_rdata = mem_word(5'd7);
    sb.push_back(mem_word(5'd7));
    tick();
    sb_check("br_instr7");
    quiet();
  endtask

  // Starts in EXEC at pc=7; ends in FETCH at pc=8
  task automatic test_stall();
    stall     = 1'b1;
    exec_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 5'd7 || instr_out !== mem_word(5'd7)) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b req=%b pc=%0d instr=%h expected 1/0/7/%h",
                 instr_valid, imem_req, pc, instr_out, mem_word(5'd7));
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (pc !== 5'd8 || imem_req !== 1'b1 || imem_addr !== 5'd8 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: pc=%0d req=%b addr=%0d valid=%b expected 8/1/8/0",
               pc, imem_req, imem_addr, instr_valid);
    end
    quiet();
  endtask

  // Starts in FETCH at pc=3
  task automatic test_halt();
    int req_seen;
    halt_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 5'd3 || halted !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_in_fetch: req=%b addr=%0d halted=%b expected 1/3/0", imem_req, imem_addr, halted);
      end
    end
    imem_ack    = 1'b1;
    instr_rdata = mem_word(5'd3);
    sb.push_back(mem_word(5'd3));
    tick();
    imem_ack = 1'b0;
    sb_check("halt_instr3");
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || halted !== 1'b0 || pc !== 5'd3) begin
      n_fail++;
      $display("FAIL halt_wait_done: valid=%b halted=%b pc=%0d expected 1/0/3", instr_valid, halted, pc);
    end
    exec_done = 1'b1;
    tick();
    n_checks++;
    if (halted !== 1'b1 || pc !== 5'd4 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_enter: halted=%b pc=%0d req=%b valid=%b err=%b expected 1/4/0/0/0",
               halted, pc, imem_req, instr_valid, fetch_err);
    end
    halt_req  = 1'b0;
    imem_ack  = 1'b1;
    req_seen  = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 5'd4) req_seen++;
    end
    n_checks++;
    if (req_seen != 0) begin
      n_fail++;
      $display("FAIL halt_sticky: %0d cycles left HALT (req=%b halted=%b pc=%0d), expected 0",
               req_seen, imem_req, halted, pc);
    end
    quiet();
  endtask

  // Starts in FETCH at pc=2
  task automatic test_timeout();
    int req_cycles;
    req_cycles = 0;
    for (int i = 0; i < 40 && imem_req === 1'b1; i++) begin
      req_cycles++;
      tick();
    end
    n_checks++;
    if (req_cycles != 15) begin
      n_fail++;
      $display("FAIL timeout_len: imem_req high %0d cycles expected 15", req_cycles);
    end
    n_checks++;
    if (fetch_err !== 1'b1 || halted !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 5'd2) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b halted=%b req=%b valid=%b pc=%0d expected 1/0/0/0/2",
               fetch_err, halted, imem_req, instr_valid, pc);
    end
    imem_ack    = 1'b1;
    instr_rdata = mem_word(5'd2);
    exec_done   = 1'b1;
    br_taken    = 1'b1;
    br_target   = 5'd5;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 5'd2) begin
      n_fail++;
      $display("FAIL timeout_sticky: err=%b req=%b valid=%b pc=%0d expected 1/0/0/2",
               fetch_err, imem_req, instr_valid, pc);
    end
    quiet();
  endtask

  // Starts in FETCH at pc=9
  task automatic test_reset_midfetch();
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 5'd9) begin
      n_fail++;
      $display("FAIL midrst_pre: req=%b addr=%0d expected 1/9", imem_req, imem_addr);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (pc !== 5'd0 || {imem_req, instr_valid, halted, fetch_err} !== 4'b0000 || instr_out !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_async: pc=%0d flags=%b instr=%h expected 0/0000/0",
               pc, {imem_req, instr_valid, halted, fetch_err}, instr_out);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL midrst_restart: req=%b addr=%0d expected 1/0", imem_req, imem_addr);
    end
    imem_ack    = 1'b1;
    instr_rdata = mem_word(imem_addr);
    sb.push_back(mem_word(5'd0));
    tick();
    sb_check("midrst_instr0");
    quiet();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    test_reset();
    test_sequential(5'd0, 32);
    test_branch();
    test_stall();
    test_reset();
    test_sequential(5'd0, 3);
    test_halt();
    test_reset();
    test_sequential(5'd0, 2);
    test_timeout();
    test_reset();
    test_sequential(5'd0, 9);
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
